// File: rtl/multicycle_sequencer_pkg.sv
// Shared constants for the LEGv8 multi-cycle sequencer: opcodes, ALU codes,
// FSM state encodings and instruction classes.
package legv8_seq_pkg;

  localparam logic [9:0] OP_ADD  = 10'b1000101100;
  localparam logic [9:0] OP_SUB  = 10'b1100101100;
  localparam logic [9:0] OP_AND  = 10'b1000101000;
  localparam logic [9:0] OP_ORR  = 10'b1010101000;
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_LDUR = 10'b1111100010;
  localparam logic [9:0] OP_STUR = 10'b1111100000;
  localparam logic [9:0] OP_CBZ  = 10'b1011010000;
  localparam logic [9:0] OP_HALT = 10'b1111111111;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_ORR   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LDUR = 3'd2,
    CLS_STUR = 3'd3,
    CLS_CBZ  = 3'd4,
    CLS_HALT = 3'd5,
    CLS_ILL  = 3'd6
  } cls_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational opcode decoder: instruction class, legality and ALU operation.
module seq_decoder
  import legv8_seq_pkg::*;
(
  input  logic [9:0] op,
  output cls_t       cls,
  output logic       legal,
  output logic [2:0] alu_op
);

  // Map opcode to class and ALU op; unknown opcodes fall out as CLS_ILL
  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALU_AND;
    case (op)
      OP_ADD:  begin cls = CLS_R;    alu_op = ALU_ADD;   end
      OP_SUB:  begin cls = CLS_R;    alu_op = ALU_SUB;   end
      OP_AND:  begin cls = CLS_R;    alu_op = ALU_AND;   end
      OP_ORR:  begin cls = CLS_R;    alu_op = ALU_ORR;   end
      OP_ADDI: begin cls = CLS_ADDI; alu_op = ALU_ADD;   end
      OP_LDUR: begin cls = CLS_LDUR; alu_op = ALU_ADD;   end
      OP_STUR: begin cls = CLS_STUR; alu_op = ALU_ADD;   end
      OP_CBZ:  begin cls = CLS_CBZ;  alu_op = ALU_PASSB; end
      OP_HALT: begin cls = CLS_HALT; alu_op = ALU_AND;   end
      default: ;
    endcase
    // HALT is recognised but does not execute, so it is not "legal" here
    legal = (cls != CLS_ILL) && (cls != CLS_HALT);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the LEGv8 datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshakes with data memory and counts
// retired instructions.
module multicycle_sequencer
  import legv8_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [9:0]       opcode,
  input  logic             zero,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state;
  logic [9:0] op_q;
  logic [7:0] wait_cnt;

  logic [9:0] dec_op;
  cls_t       cls;
  logic       legal;
  logic [2:0] dec_alu;

  logic pc_w, ir_w, reg_w, mem_r, mem_w;
  logic retire;

  // DECODE looks at the live opcode; every later step uses the captured op_q
  assign dec_op = (state == S_DECODE) ? opcode : op_q;

  seq_decoder u_dec (
    .op     (dec_op),
    .cls    (cls),
    .legal  (legal),
    .alu_op (dec_alu)
  );

  // Per-state control decode; the STUR ack path is Mealy on dmem_ack
  always_comb begin
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_AND;
    retire     = 1'b0;
    case (state)
      S_FETCH: ir_w = 1'b1;
      S_EXEC: begin
        if (cls == CLS_CBZ) begin
          alu_op = ALU_PASSB;
          pc_w   = 1'b1;
          pc_src = zero;
          retire = 1'b1;
        end else begin
          alu_op  = dec_alu;
          alu_src = (cls != CLS_R);
        end
      end
      S_MEM: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        mem_r   = (cls == CLS_LDUR);
        mem_w   = (cls == CLS_STUR);
        if (cls == CLS_STUR && dmem_ack) begin
          pc_w   = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        reg_w      = 1'b1;
        pc_w       = 1'b1;
        mem_to_reg = (cls == CLS_LDUR);
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset kills every write strobe immediately so an abandoned instruction
  // cannot commit anything in the reset cycle
  assign pc_write  = pc_w  & ~reset;
  assign ir_write  = ir_w  & ~reset;
  assign reg_write = reg_w & ~reset;
  assign mem_read  = mem_r & ~reset;
  assign mem_write = mem_w & ~reset;

  assign busy      = (state != S_IDLE) && (state != S_HALTED) && (state != S_ERROR);
  assign state_out = state;

  // State transitions, opcode capture, memory wait timer and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      wait_cnt    <= '0;
      halted      <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          if (legal) begin
            state <= S_EXEC;
          end else if (cls == CLS_HALT) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        S_EXEC: begin
          case (cls)
            CLS_CBZ:  state <= S_FETCH;
            CLS_LDUR,
            CLS_STUR: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            default:  state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            state <= (cls == CLS_LDUR) ? S_WB : S_FETCH;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            state <= S_ERROR;
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        default: state <= state;
      endcase
      if (retire && (instr_count != {CNT_W{1'b1}}))
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus pushes the expected
// per-cycle output snapshot, a negedge monitor pops and compares it.
module tb_multicycle_sequencer;
  import legv8_seq_pkg::*;

  localparam int CW = 3;  // narrow counter so saturation is reachable

  typedef struct packed {
    logic          pc_write, pc_src, ir_write, reg_write;
    logic          mem_read, mem_write, alu_src, mem_to_reg;
    logic [2:0]    alu_op;
    logic          busy, halted, error;
    logic [2:0]    st;
    logic [CW-1:0] cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset, start, zero, dmem_ack;
  logic [9:0]    opcode;
  logic          pc_write, pc_src, ir_write, reg_write, mem_read, mem_write;
  logic          alu_src, mem_to_reg, busy, halted, error;
  logic [2:0]    alu_op, state_out;
  logic [CW-1:0] instr_count;

  obs_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .zero(zero),
    .dmem_ack(dmem_ack), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .busy(busy), .halted(halted), .error(error),
    .state_out(state_out), .instr_count(instr_count)
  );

  // Monitor: compare the DUT snapshot against the oldest expectation
  always @(negedge clk) begin
    obs_t  e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
            alu_src, mem_to_reg, alu_op, busy, halted, error, state_out,
            instr_count};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", n, a, e);
      end
    end
  end

  // Baseline snapshot for a state: no strobes, status flags from the state
  function automatic obs_t b(input logic [2:0] st, input int c);
    obs_t o = '0;
    o.st     = st;
    o.cnt    = CW'(c);
    o.busy   = (st >= 3'd1) && (st <= 3'd5);
    o.halted = (st == 3'd6);
    o.error  = (st == 3'd7);
    return o;
  endfunction

  task automatic cyc(input obs_t o, input string nm);
    exp_q.push_back(o);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [9:0] op, input int c, input string nm);
    obs_t o;
    opcode = op;
    o = b(1, c); o.ir_write = 1'b1;
    cyc(o, {nm, "_fetch"});
    cyc(b(2, c), {nm, "_decode"});
    opcode = 10'h000;  // later steps must rely on the captured opcode
  endtask

  task automatic exec(input int c, input logic [2:0] aop, input logic asrc, input string nm);
    obs_t o;
    o = b(3, c); o.alu_op = aop; o.alu_src = asrc;
    cyc(o, {nm, "_exec"});
  endtask

  task automatic wb(input int c, input logic ld, input string nm);
    obs_t o;
    o = b(5, c); o.reg_write = 1'b1; o.pc_write = 1'b1; o.mem_to_reg = ld;
    cyc(o, {nm, "_wb"});
  endtask

  task automatic rtype(input logic [9:0] op, input logic [2:0] aop, input logic asrc,
                       input int c, input string nm);
    fetch_decode(op, c, nm);
    exec(c, aop, asrc, nm);
    wb(c, 1'b0, nm);
  endtask

  task automatic cbz(input logic z, input int c, input string nm);
    obs_t o;
    fetch_decode(OP_CBZ, c, nm);
    zero = z;
    o = b(3, c); o.alu_op = 3'b111; o.pc_write = 1'b1; o.pc_src = z;
    cyc(o, {nm, "_exec"});
    zero = 1'b0;
  endtask

  function automatic obs_t memo(input int c, input logic rd);
    obs_t o = b(4, c);
    o.alu_op = 3'b010; o.alu_src = 1'b1;
    o.mem_read = rd; o.mem_write = ~rd;
    return o;
  endfunction

  task automatic start_from_idle(input int c);
    start = 1'b1;
    cyc(b(0, c), "idle_start");
    start = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(b(0, 0), "after_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    reset = 1'b1; start = 1'b0; zero = 1'b0; dmem_ack = 1'b0; opcode = 10'h000;
    @(posedge clk); #1;
    cyc(b(0, 0), "reset_state");
    reset = 1'b0;

    // Program stream: ADD, LDUR(3 wait), CBZ z=1/0, STUR, ADDI, ORR, SUB, HALT
    start_from_idle(0);
    rtype(OP_ADD, 3'b010, 1'b0, 0, "add");

    fetch_decode(OP_LDUR, 1, "ldur");
    exec(1, 3'b010, 1'b1, "ldur");
    repeat (3) cyc(memo(1, 1'b1), "ldur_mem_wait");
    dmem_ack = 1'b1;
    cyc(memo(1, 1'b1), "ldur_mem_ack");
    dmem_ack = 1'b0;
    wb(1, 1'b1, "ldur");

    cbz(1'b1, 2, "cbz_taken");
    cbz(1'b0, 3, "cbz_not_taken");

    fetch_decode(OP_STUR, 4, "stur");
    exec(4, 3'b010, 1'b1, "stur");
    dmem_ack = 1'b1;
    o = memo(4, 1'b0); o.pc_write = 1'b1;
    cyc(o, "stur_mem_ack");
    dmem_ack = 1'b0;

    rtype(OP_ADDI, 3'b010, 1'b1, 5, "addi");
    rtype(OP_ORR,  3'b001, 1'b0, 6, "orr");
    rtype(OP_SUB,  3'b110, 1'b0, 7, "sub_saturate");

    fetch_decode(OP_HALT, 7, "halt");
    start = 1'b1;
    cyc(b(6, 7), "halted");
    cyc(b(6, 7), "halted_ignores_start");
    start = 1'b0;

    // Illegal opcode goes straight to ERROR after DECODE
    do_reset();
    start_from_idle(0);
    fetch_decode(10'h000, 0, "illegal");
    cyc(b(7, 0), "illegal_error");

    // STUR that never sees an ack times out after 15 MEM cycles
    do_reset();
    start_from_idle(0);
    fetch_decode(OP_STUR, 0, "stur_to");
    exec(0, 3'b010, 1'b1, "stur_to");
    repeat (15) cyc(memo(0, 1'b0), "stur_to_mem");
    start = 1'b1;
    cyc(b(7, 0), "timeout_error");
    cyc(b(7, 0), "timeout_ignores_start");
    start = 1'b0;

    // Reset in the middle of an LDUR memory wait
    do_reset();
    start_from_idle(0);
    fetch_decode(OP_LDUR, 0, "ldur_rst");
    exec(0, 3'b010, 1'b1, "ldur_rst");
    repeat (2) cyc(memo(0, 1'b1), "ldur_rst_mem");
    reset = 1'b1;
    o = memo(0, 1'b1); o.mem_read = 1'b0;
    cyc(o, "reset_kills_mem_read");
    reset = 1'b0;
    cyc(b(0, 0), "idle_after_abort");

    repeat (4) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the existing LEGv8 datapath: PC, instruction memory, register file, ALU, mux1/mux2/mux3 and data memory.
- Replaces the single-cycle combinational controller. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps.
- Generates per-step strobes and handshakes with data memory (req/ack) so the memory may take a variable number of cycles.
- Reports busy, halted, error and a retired-instruction count.

Parameters:
- MEM_TIMEOUT, 15, max cycles spent in MEM without dmem_ack before entering ERROR (1..255).
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin execution from IDLE (pulse or level).
- opcode  in  10  instruction[31:22] from instruction memory.
- zero  in  1  ALU zero flag.
- dmem_ack  in  1  data memory completed the current read/write.
- pc_write  out  1  PC register load enable.
- pc_src  out  1  mux1 select: 0 = PC+4 (adder1), 1 = branch target (adder2).
- ir_write  out  1  latch instruction memory output.
- reg_write  out  1  register file write enable.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- alu_src  out  1  mux3 select: 0 = register, 1 = sign-extended immediate.
- mem_to_reg  out  1  mux2 select: 1 = data memory, 0 = ALU.
- alu_op  out  3  ALU operation.
- busy  out  1  high in every state except IDLE, HALTED and ERROR.
- halted  out  1  sticky HALT reached.
- error  out  1  sticky illegal opcode or memory timeout.
- state_out  out  3  current state encoding, for debug.
- instr_count  out  CNT_W  retired instructions; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high): on the next edge the state goes to IDLE, all counters clear, and halted/error clear. While reset=1, every strobe output (pc_write, ir_write, reg_write, mem_read, mem_write) is forced to 0 combinationally. A reset mid-instruction abandons it, with no write issued.
- Reset values: every output is 0; alu_op = ALU_AND (000); state_out = IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, ERROR=7.
- IDLE: start=1 moves to FETCH. start is ignored in any other state.
- FETCH (1 cycle): ir_write=1. Next state is DECODE.
- DECODE (1 cycle):
  - opcode is captured into op_q; all later steps use op_q, not the live opcode input.
  - Legal opcode goes to EXEC. OP_HALT goes to HALTED. Any other opcode goes to ERROR.
- EXEC:
  - alu_op and alu_src are driven from op_q.
  - R-type (ADD/SUB/AND/ORR) and ADDI go to WB.
  - LDUR/STUR go to MEM.
  - CBZ: alu_op=ALU_PASSB, alu_src=0, pc_write=1, pc_src=zero, instruction retires, next state FETCH.
- MEM:
  - alu_op=ALU_ADD and alu_src=1 are held throughout.
  - LDUR holds mem_read=1 and STUR holds mem_write=1 until dmem_ack=1 is sampled.
  - LDUR with ack goes to WB.
  - STUR with ack: pc_write=1 and retire in that same cycle (Mealy on dmem_ack), then FETCH.
  - A wait counter increments on every MEM cycle without ack. When it reaches MEM_TIMEOUT, the next state is ERROR and strobes drop.
  - The counter clears on entering MEM.
- WB (1 cycle): reg_write=1, mem_to_reg=(op_q==OP_LDUR), pc_write=1, pc_src=0, retire. Next state FETCH.
- Latency in cycles, with W = ack wait cycles:
  - CBZ: 3.
  - R-type/ADDI: 4.
  - STUR: 4+W.
  - LDUR: 5+W.
- Retire: instr_count increments once per completed instruction and saturates at 2^CNT_W-1.
- HALTED and ERROR: absorbing until reset; all strobes 0.
- alu_op mapping: AND=000, ORR=001, ADD=010, SUB=110, PASSB=111. ADDI/LDUR/STUR use ADD.

Decomposition:
- Package legv8_seq_pkg contains:
  - Opcode constants: OP_ADD=10'b1000101100, OP_SUB=10'b1100101100, OP_AND=10'b1000101000, OP_ORR=10'b1010101000, OP_ADDI=10'b1001000100, OP_LDUR=10'b1111100010, OP_STUR=10'b1111100000, OP_CBZ=10'b1011010000, OP_HALT=10'b1111111111.
  - ALU_* constants.
  - State encodings.
- One sub-module, seq_decoder: combinational, maps op_q to instruction class, legal flag and alu_op.

Test Plan:
- reset, start pulse, opcode=OP_ADD -> ir_write in cycle 1, alu_op=010/alu_src=0 in cycle 3, reg_write=1 and pc_write=1 in cycle 4, instr_count=1.
- OP_LDUR with dmem_ack delayed 3 cycles -> mem_read high exactly 4 cycles; WB has mem_to_reg=1 and reg_write=1; total 8 cycles.
- OP_CBZ with zero=1 -> EXEC pc_write=1, pc_src=1. Repeat with zero=0 -> pc_src=0. reg_write never asserted.
- OP_STUR with dmem_ack never asserted, MEM_TIMEOUT=15 -> mem_write high 15 cycles, then error=1, state_out=7, strobes 0; start ignored.
- opcode=10'h000 -> ERROR after DECODE. OP_HALT -> halted=1, busy=0, instr_count unchanged.
- reset asserted during MEM of an LDUR -> mem_read=0 in the same cycle; IDLE and all outputs 0 on the next cycle; instr_count=0.
